alu_issue_stage: RTL and testbench

//  Command-buffering issue stage directly upstream of the combinational alu (ADD/SUB/MUL/XOR).

---
 rtl/alu_issue_stage.sv | 164 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: buffers {a,b,op} commands in a DEPTH-entry FIFO, drives the external
// combinational alu from registers, captures its result and returns it over valid/ready.
// Optional build macro ALU_FLAGS_EN adds the rsp_zero / rsp_neg result flags.
module alu_issue_stage #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [7:0]               cmd_a,
    input  logic [7:0]               cmd_b,
    input  logic [1:0]               cmd_op,
    output logic [7:0]               alu_a,
    output logic [7:0]               alu_b,
    output logic [1:0]               alu_op,
    input  logic [15:0]              alu_result,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [15:0]              rsp_data,
`ifdef ALU_FLAGS_EN
    output logic                     rsp_zero,
    output logic                     rsp_neg,
`endif
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     busy
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_XOR = 2'b11
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    // FIFO entry layout: {op[17:16], a[15:8], b[7:0]}
    logic [17:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             capture;
    logic             rsp_done;

    assign full       = (count == (PTR_W + 1)'(DEPTH));
    assign empty      = (count == '0);
    assign cmd_ready  = !full;
    assign push       = cmd_valid && !full;
    assign fifo_level = count;
    assign busy       = (state != IDLE) || !empty;

    // FIFO control: pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage: payload only, never needs clearing since count gates every read
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b};
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // FSM next state and strobes; pop only sees entries registered before this edge
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        capture    = 1'b0;
        rsp_done   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                capture    = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_done = 1'b1;
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = DRIVE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // alu operand registers: change only when a command is popped
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a  <= 8'd0;
            alu_b  <= 8'd0;
            alu_op <= OP_ADD;
        end else if (pop) begin
            {alu_op, alu_a, alu_b} <= mem[rd_ptr];
        end
    end

    // response register: capture in DRIVE, hold until accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= 16'd0;
        end else if (capture) begin
            rsp_valid <= 1'b1;
            rsp_data  <= alu_result;
        end else if (rsp_done) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef ALU_FLAGS_EN
    // result flags travel with rsp_data and are captured on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_zero <= 1'b0;
            rsp_neg  <= 1'b0;
        end else if (capture) begin
            rsp_zero <= (alu_result == 16'd0);
            rsp_neg  <= (alu_op == OP_SUB) && (alu_a < alu_b);
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: bench for alu_issue_stage with a behavioural alu, a response
// scoreboard fed from accepted commands, directed scenarios and a randomized phase.
module tb_alu_issue_stage;

    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [7:0]             cmd_a;
    logic [7:0]             cmd_b;
    logic [1:0]             cmd_op;
    logic [7:0]             alu_a;
    logic [7:0]             alu_b;
    logic [1:0]             alu_op;
    logic [15:0]            alu_result;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [15:0]            rsp_data;
`ifdef ALU_FLAGS_EN
    logic                   rsp_zero;
    logic                   rsp_neg;
`endif
    logic [$clog2(DEPTH):0] fifo_level;
    logic                   busy;

    int n_cmp = 0;
    int n_err = 0;
    int n_rsp = 0;
    logic [17:0] sb_q[$];   // {neg, zero, data}
    bit done_push;

    alu_issue_stage #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
`ifdef ALU_FLAGS_EN
        .rsp_zero   (rsp_zero),
        .rsp_neg    (rsp_neg),
`endif
        .fifo_level (fifo_level),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // behavioural combinational alu
    always_comb begin
        alu_result = 16'd0;
        case (alu_op)
            2'd0:    alu_result = {7'd0, ({1'b0, alu_a} + {1'b0, alu_b})};
            2'd1:    alu_result = {8'd0, alu_a} - {8'd0, alu_b};
            2'd2:    alu_result = {8'd0, alu_a} * {8'd0, alu_b};
            default: alu_result = {8'd0, alu_a ^ alu_b};
        endcase
    end

    function automatic logic [15:0] ref_result(int a, int b, int op);
        int r;
        case (op)
            0:       r = a + b;
            1:       r = a - b;
            2:       r = a * b;
            default: r = a ^ b;
        endcase
        return r[15:0];
    endfunction

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_valid = 1'b1;
        for (int i = 0; i < 200 && !cmd_ready; i++) tick();
        if (!cmd_ready) chk_eq("push_timeout", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int i = 0; i < 400 && (busy || sb_q.size() != 0); i++) tick();
        chk_eq("drain_busy", 32'(busy), 0);
        chk_eq("drain_queue", sb_q.size(), 0);
    endtask

    task automatic wait_rsp(input string tag, input logic [15:0] exp);
        for (int i = 0; i < 50 && !rsp_valid; i++) tick();
        chk_eq(tag, 32'(rsp_data), 32'(exp));
    endtask

    // monitor: scoreboard of accepted commands vs returned responses, stall stability
    initial begin : monitor
        bit          prev_stall;
        logic [15:0] prev_data;
        logic [17:0] e;
        logic [15:0] r;
        prev_stall = 1'b0;
        prev_data  = 16'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb_q.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk_eq("stall_valid", 32'(rsp_valid), 1);
                    chk_eq("stall_data", 32'(rsp_data), 32'(prev_data));
                end
                if (rsp_valid && rsp_ready) begin
                    if (sb_q.size() == 0) begin
                        chk_eq("rsp_unexpected", 32'(rsp_valid), 0);
                    end else begin
                        e = sb_q.pop_front();
                        n_rsp++;
                        chk_eq("rsp_data", 32'(rsp_data), 32'(e[15:0]));
`ifdef ALU_FLAGS_EN
                        chk_eq("rsp_zero", 32'(rsp_zero), 32'(e[16]));
                        chk_eq("rsp_neg", 32'(rsp_neg), 32'(e[17]));
`endif
                    end
                end
                if (cmd_valid && cmd_ready) begin
                    r = ref_result(int'(cmd_a), int'(cmd_b), int'(cmd_op));
                    sb_q.push_back({(cmd_op == 2'd1) && (cmd_a < cmd_b), r == 16'd0, r});
                end
                prev_stall = rsp_valid && !rsp_ready;
                prev_data  = rsp_data;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int base;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = 8'd0;
        cmd_b     = 8'd0;
        cmd_op    = 2'd0;
        rsp_ready = 1'b0;
        done_push = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        chk_eq("rst_rsp_valid", 32'(rsp_valid), 0);
        chk_eq("rst_level", 32'(fifo_level), 0);
        chk_eq("rst_cmd_ready", 32'(cmd_ready), 1);
        chk_eq("rst_alu_op", 32'(alu_op), 0);
        chk_eq("rst_alu_a", 32'(alu_a), 0);
        chk_eq("rst_busy", 32'(busy), 0);
        chk_eq("rst_rsp_data", 32'(rsp_data), 0);

        // latency and basic results
        rsp_ready = 1'b1;
        cmd_a = 8'd200; cmd_b = 8'd100; cmd_op = 2'd0; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk_eq("lat1_valid", 32'(rsp_valid), 0);
        chk_eq("lat1_level", 32'(fifo_level), 1);
        tick();
        chk_eq("lat2_valid", 32'(rsp_valid), 0);
        chk_eq("lat2_alu_a", 32'(alu_a), 200);
        chk_eq("lat2_level", 32'(fifo_level), 0);
        tick();
        chk_eq("lat3_valid", 32'(rsp_valid), 1);
        chk_eq("add_data", 32'(rsp_data), 32'h012C);
        push_one(8'd3, 8'd5, 2'd1);
        wait_rsp("sub_data", 16'hFFFE);
`ifdef ALU_FLAGS_EN
        chk_eq("sub_neg", 32'(rsp_neg), 1);
`endif
        drain();

        // fill to full while the first result is held
        rsp_ready = 1'b0;
        base = n_rsp;
        push_one(8'd255, 8'd255, 2'd2);
        push_one(8'hF0, 8'h0F, 2'd3);
        push_one(8'd0, 8'd0, 2'd0);
        push_one(8'd1, 8'd1, 2'd1);
        push_one(8'd7, 8'd8, 2'd0);
        chk_eq("full_level", 32'(fifo_level), DEPTH);
        chk_eq("full_ready", 32'(cmd_ready), 0);
        chk_eq("full_rsp_valid", 32'(rsp_valid), 1);
        chk_eq("full_rsp_data", 32'(rsp_data), 32'hFE01);
        chk_eq("full_alu_op", 32'(alu_op), 2);
        cmd_a = 8'd16; cmd_b = 8'd16; cmd_op = 2'd2; cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_eq("hold_ready", 32'(cmd_ready), 0);
            chk_eq("hold_level", 32'(fifo_level), DEPTH);
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 50 && !cmd_ready; i++) tick();
        chk_eq("extra_ready", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        drain();
        chk_eq("full_rsp_count", n_rsp - base, 6);

        // simultaneous push and pop at level 2
        rsp_ready = 1'b0;
        push_one(8'd11, 8'd22, 2'd0);
        push_one(8'd33, 8'd44, 2'd3);
        push_one(8'd55, 8'd66, 2'd2);
        chk_eq("pp_level_before", 32'(fifo_level), 2);
        chk_eq("pp_rsp_valid", 32'(rsp_valid), 1);
        rsp_ready = 1'b1;
        push_one(8'd77, 8'd88, 2'd1);
        rsp_ready = 1'b0;
        chk_eq("pp_level_after", 32'(fifo_level), 2);
        drain();

        // randomized traffic with random backpressure
        base = n_rsp;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    if ($urandom_range(0, 3) == 0) tick();
                    push_one(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                             2'($urandom_range(0, 3)));
                end
                done_push = 1'b1;
            end
            begin
                while (!done_push) begin
                    rsp_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        drain();
        chk_eq("rand_rsp_count", n_rsp - base, 40);

        // reset while a response is held and three commands are queued
        rsp_ready = 1'b0;
        push_one(8'd10, 8'd20, 2'd0);
        push_one(8'd30, 8'd40, 2'd1);
        push_one(8'd50, 8'd60, 2'd2);
        push_one(8'd70, 8'd80, 2'd3);
        chk_eq("pre_rst_level", 32'(fifo_level), 3);
        chk_eq("pre_rst_valid", 32'(rsp_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_eq("mid_rst_valid", 32'(rsp_valid), 0);
        chk_eq("mid_rst_level", 32'(fifo_level), 0);
        chk_eq("mid_rst_busy", 32'(busy), 0);
        chk_eq("mid_rst_ready", 32'(cmd_ready), 1);
        chk_eq("mid_rst_data", 32'(rsp_data), 0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_eq("post_rst_valid", 32'(rsp_valid), 0);
        end
        push_one(8'd9, 8'd9, 2'd2);
        wait_rsp("post_rst_data", 16'd81);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
